// File: rtl/mmio_frame_reader.sv
// Once-per-frame BRAM port-B reader: fetches NUM_REGS game-state words and commits them atomically.
// Optional FRAME_READER_OVERRUN_CNT_EN adds a saturating count of vblank pulses ignored while busy.
module mmio_frame_reader #(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 16'hC010,
    parameter int                    NUM_REGS   = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           vblank_start,
    output logic [ADDR_WIDTH-1:0]          addr_b,
    input  logic [DATA_WIDTH-1:0]          q_b,
    output logic [NUM_REGS*DATA_WIDTH-1:0] obj_data,
    output logic                           frame_valid,
    output logic                           busy
`ifdef FRAME_READER_OVERRUN_CNT_EN
    ,
    output logic [7:0]                     overrun_cnt
`endif
);

    localparam int IDX_W = $clog2(NUM_REGS + 1);

    typedef enum logic [1:0] {IDLE, FETCH, COMMIT} state_t;

    state_t                               state_q, state_d;
    logic [IDX_W-1:0]                     idx_q, idx_d;
    logic [ADDR_WIDTH-1:0]                addr_b_q, addr_b_d;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  shadow_q, shadow_d;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  obj_data_q, obj_data_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            addr_b_q   <= BASE_ADDR;
            shadow_q   <= '0;
            obj_data_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            addr_b_q   <= addr_b_d;
            shadow_q   <= shadow_d;
            obj_data_q <= obj_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        addr_b_d   = BASE_ADDR;
        shadow_d   = shadow_q;
        obj_data_d = obj_data_q;
        case (state_q)
            IDLE: begin
                if (vblank_start) begin
                    state_d = FETCH;
                    idx_d   = '0;
                end
            end
            FETCH: begin
                // q_b in fetch cycle idx answers the address issued in cycle idx-1
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (32'(idx_q) == i + 1) shadow_d[i] = q_b;
                end
                if (32'(idx_q) == NUM_REGS) begin
                    // Load the output on the edge into COMMIT so new data and
                    // frame_valid appear together in the commit cycle.
                    state_d    = COMMIT;
                    idx_d      = '0;
                    obj_data_d = shadow_d;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                    if (32'(idx_q) < NUM_REGS - 1)
                        addr_b_d = BASE_ADDR + ADDR_WIDTH'(idx_q + IDX_W'(1));
                end
            end
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef FRAME_READER_OVERRUN_CNT_EN
    logic [7:0] overrun_cnt_q, overrun_cnt_d;

    always_comb begin
        overrun_cnt_d = overrun_cnt_q;
        if (vblank_start && state_q != IDLE && overrun_cnt_q != 8'hFF)
            overrun_cnt_d = overrun_cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) overrun_cnt_q <= '0;
        else       overrun_cnt_q <= overrun_cnt_d;
    end

    assign overrun_cnt = overrun_cnt_q;
`endif

    assign addr_b      = addr_b_q;
    assign obj_data    = obj_data_q;
    assign frame_valid = (state_q == COMMIT);
    assign busy        = (state_q != IDLE);

endmodule
